// File: rtl/uc_pkg.sv
// Shared definitions for the microc control unit: opcode encodings, decode
// prefixes, FSM state type and the illegal-opcode classifier.
package uc_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000100;
    localparam logic [5:0] OP_JZ   = 6'b000101;
    localparam logic [5:0] OP_JNZ  = 6'b000110;
    localparam logic [5:0] OP_HALT = 6'b000111;

    localparam logic       PFX_ALU = 1'b1;
    localparam logic [1:0] PFX_LI  = 2'b01;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    // 000001-000011 and 001xxx have no meaning in the instruction set
    function automatic logic is_illegal_op(input logic [5:0] opc);
        return (opc[5:4] == 2'b00) &&
               (opc[3] || (!opc[2] && (opc[1:0] != 2'b00)));
    endfunction

endpackage

// File: rtl/uc_dec.sv
// Purely combinational instruction decoder: Opcode and z to raw datapath
// controls plus instruction-class flags. No state or reset gating here.
module uc_dec
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       wez,
    output logic [2:0] op,
    output logic       is_jump,
    output logic       is_halt,
    output logic       is_illegal
);

    // Raw decode of the current opcode
    always_comb begin
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        op         = 3'b000;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (opcode[5] == PFX_ALU) begin
            op  = opcode[4:2];
            we3 = 1'b1;
            wez = 1'b1;
        end else if (opcode[5:4] == PFX_LI) begin
            we3   = 1'b1;
            s_inm = 1'b1;
        end else begin
            case (opcode)
                OP_NOP: begin
                    s_inc = 1'b1;
                end
                OP_J: begin
                    s_inc   = 1'b0;
                    is_jump = 1'b1;
                end
                OP_JZ: begin
                    s_inc   = ~z;
                    is_jump = 1'b1;
                end
                OP_JNZ: begin
                    s_inc   = z;
                    is_jump = 1'b1;
                end
                OP_HALT: begin
                    s_inc   = 1'b0;
                    is_halt = 1'b1;
                end
                default: begin
                    is_illegal = is_illegal_op(opcode);
                end
            endcase
        end
    end

endmodule

// File: rtl/uc.sv
// Control unit for the single-cycle microc datapath: decode gating by the
// RUN/HALT FSM and reset, sticky illegal flag and saturating debug counters.
module uc
    import uc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] br_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       raw_s_inc, raw_s_inm, raw_we3, raw_wez;
    logic [2:0] raw_op;
    logic       is_jump, is_halt, is_illegal;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic             run_s;

    uc_dec u_dec (
        .opcode     (Opcode),
        .z          (z),
        .s_inc      (raw_s_inc),
        .s_inm      (raw_s_inm),
        .we3        (raw_we3),
        .wez        (raw_wez),
        .op         (raw_op),
        .is_jump    (is_jump),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign run_s = (state_q == S_RUN);

    // Control outputs: reset forces sequential fetch with no writes, HALT parks the PC
    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        Op    = 3'b000;
        if (!reset) begin
            s_inc = 1'b1;
        end else if (!run_s) begin
            s_inc = 1'b0;
        end else begin
            s_inc = raw_s_inc;
            s_inm = raw_s_inm;
            we3   = raw_we3;
            wez   = raw_wez;
            Op    = raw_op;
        end
    end

    // Next-state for the FSM; HALT is only left through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Sticky flag and saturating counters, all frozen outside RUN
    always_comb begin
        illegal_d   = illegal_q;
        instr_cnt_d = instr_cnt_q;
        br_cnt_d    = br_cnt_q;
        if (run_s) begin
            illegal_d = illegal_q | is_illegal;
            if (instr_cnt_q != CNT_MAX) begin
                instr_cnt_d = instr_cnt_q + CNT_ONE;
            end else begin
                instr_cnt_d = instr_cnt_q;
            end
            if (is_jump && !raw_s_inc && (br_cnt_q != CNT_MAX)) begin
                br_cnt_d = br_cnt_q + CNT_ONE;
            end else begin
                br_cnt_d = br_cnt_q;
            end
        end else begin
            illegal_d = illegal_q;
        end
    end

    // State and debug registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            illegal_q   <= 1'b0;
            instr_cnt_q <= {CNT_W{1'b0}};
            br_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            instr_cnt_q <= instr_cnt_d;
            br_cnt_q    <= br_cnt_d;
        end
    end

    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign instr_cnt = instr_cnt_q;
    assign br_cnt    = br_cnt_q;

endmodule

// File: tb/tb_uc.sv
// Directed bench for uc: a 16-bit-counter instance and a 4-bit-counter
// instance share stimulus; expected values are hand-computed.
module tb_uc;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Opcode;
    logic        z;

    logic        s_inc, s_inm, we3, wez, halted, illegal;
    logic [2:0]  Op;
    logic [15:0] instr_cnt, br_cnt;

    logic        s_inc4, s_inm4, we34, wez4, halted4, illegal4;
    logic [2:0]  Op4;
    logic [3:0]  instr_cnt4, br_cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uc #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
        .halted(halted), .illegal(illegal),
        .instr_cnt(instr_cnt), .br_cnt(br_cnt)
    );

    uc #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
        .s_inc(s_inc4), .s_inm(s_inm4), .we3(we34), .wez(wez4), .Op(Op4),
        .halted(halted4), .illegal(illegal4),
        .instr_cnt(instr_cnt4), .br_cnt(br_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // apply inputs mid-cycle, then settle
    task automatic drive(input logic [5:0] opc, input logic zv);
        @(negedge clk);
        Opcode = opc;
        z      = zv;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic e_inc, input logic e_inm,
                           input logic e_we3, input logic e_wez, input logic [2:0] e_op);
        chk({tag, ".s_inc"}, 32'(s_inc), 32'(e_inc));
        chk({tag, ".s_inm"}, 32'(s_inm), 32'(e_inm));
        chk({tag, ".we3"},   32'(we3),   32'(e_we3));
        chk({tag, ".wez"},   32'(wez),   32'(e_wez));
        chk({tag, ".Op"},    32'(Op),    32'(e_op));
    endtask

    task automatic chk_reg(input string tag, input logic e_h, input logic e_ill,
                           input int e_ic, input int e_bc);
        chk({tag, ".halted"},    32'(halted),    32'(e_h));
        chk({tag, ".illegal"},   32'(illegal),   32'(e_ill));
        chk({tag, ".instr_cnt"}, 32'(instr_cnt), 32'(e_ic));
        chk({tag, ".br_cnt"},    32'(br_cnt),    32'(e_bc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        Opcode = 6'b100101;
        z      = 1'b0;
        #3;
        chk_ctl("rst", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        chk_reg("rst", 1'b0, 1'b0, 0, 0);
        edge_wait();
        edge_wait();
        chk_reg("rst_hold", 1'b0, 1'b0, 0, 0);

        // release reset with an ALU op
        @(negedge clk);
        reset  = 1'b1;
        Opcode = 6'b101100;
        #1;
        chk_ctl("alu", 1'b1, 1'b0, 1'b1, 1'b1, 3'b011);
        edge_wait();
        chk_reg("alu", 1'b0, 1'b0, 1, 0);

        drive(6'b010000, 1'b0);
        chk_ctl("li", 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        edge_wait();
        drive(6'b000000, 1'b0);
        chk_ctl("nop", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        edge_wait();
        chk_reg("nop", 1'b0, 1'b0, 3, 0);

        drive(6'b000100, 1'b1);
        chk_ctl("j", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        edge_wait();
        chk_reg("j", 1'b0, 1'b0, 4, 1);
        drive(6'b000101, 1'b1);
        chk("jz_t.s_inc", 32'(s_inc), 32'd0);
        edge_wait();
        chk("jz_t.br", 32'(br_cnt), 32'd2);
        drive(6'b000101, 1'b0);
        chk("jz_n.s_inc", 32'(s_inc), 32'd1);
        edge_wait();
        chk("jz_n.br", 32'(br_cnt), 32'd2);
        drive(6'b000110, 1'b0);
        chk("jnz_t.s_inc", 32'(s_inc), 32'd0);
        edge_wait();
        chk("jnz_t.br", 32'(br_cnt), 32'd3);
        drive(6'b000110, 1'b1);
        chk("jnz_n.s_inc", 32'(s_inc), 32'd1);
        edge_wait();
        chk_reg("jnz_n", 1'b0, 1'b0, 8, 3);

        // illegal opcode executes as NOP, flag is sticky
        drive(6'b001000, 1'b0);
        chk_ctl("ill", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("ill.pre", 32'(illegal), 32'd0);
        edge_wait();
        chk_reg("ill", 1'b0, 1'b1, 9, 3);
        for (int i = 0; i < 5; i++) begin
            drive(6'b000000, 1'b0);
            edge_wait();
        end
        chk_reg("ill_sticky", 1'b0, 1'b1, 14, 3);

        // HALT cycle counts, then everything freezes
        drive(6'b000111, 1'b0);
        chk_ctl("halt", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("halt.pre", 32'(halted), 32'd0);
        edge_wait();
        chk_reg("halt", 1'b1, 1'b1, 15, 3);
        drive(6'b111111, 1'b0);
        chk_ctl("halt_alu", 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) edge_wait();
        drive(6'b000100, 1'b0);
        chk("halt_j.s_inc", 32'(s_inc), 32'd0);
        for (int i = 0; i < 5; i++) edge_wait();
        chk_reg("halt_frz", 1'b1, 1'b1, 15, 3);

        // reset returns to RUN and clears flags
        @(negedge clk);
        reset  = 1'b0;
        Opcode = 6'b111111;
        #1;
        chk_ctl("rst2", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        chk_reg("rst2", 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("run2.we3", 32'(we3), 32'd1);

        // saturation: reset, 20 NOPs then 20 taken jumps
        @(negedge clk);
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset  = 1'b1;
        Opcode = 6'b000000;
        for (int i = 0; i < 20; i++) edge_wait();
        chk("sat.ic4", 32'(instr_cnt4), 32'h0000000f);
        chk("sat.ic16", 32'(instr_cnt), 32'd20);
        drive(6'b000100, 1'b0);
        for (int i = 0; i < 20; i++) edge_wait();
        chk("sat.bc4", 32'(br_cnt4), 32'h0000000f);
        chk("sat.ic4b", 32'(instr_cnt4), 32'h0000000f);
        chk("sat.bc16", 32'(br_cnt), 32'd20);
        chk("sat.ic16b", 32'(instr_cnt), 32'd40);
        chk("sat.ill", 32'(illegal4), 32'd0);

        // low illegal range
        drive(6'b000011, 1'b0);
        chk("ill3.s_inc", 32'(s_inc), 32'd1);
        edge_wait();
        chk("ill3.flag", 32'(illegal), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
